// File: rtl/ieee488_drive_hs.sv
// Device-side IEEE-488 DAV/NRFD/NDAC handshake sequencer for an emulated PET drive.
// All bus pins are electrical levels (1 = released, 0 = asserted); host-side bytes are true polarity.
module ieee488_drive_hs #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic [7:0] bus_data_i,
  input  logic       bus_atn_i,
  input  logic       bus_dav_i,
  input  logic       bus_eoi_i,
  input  logic       bus_nrfd_i,
  input  logic       bus_ndac_i,
  output logic [7:0] bus_data_o,
  output logic       bus_dav_o,
  output logic       bus_eoi_o,
  output logic       bus_nrfd_o,
  output logic       bus_ndac_o,
  input  logic       listen,
  input  logic       talk,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_eoi,
  output logic       rx_atn,
  input  logic       rx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  output logic       tx_ready,
  output logic       tx_err
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L_WAIT   = 3'd1,
    L_ACK    = 3'd2,
    T_SETTLE = 3'd3,
    T_DAV    = 3'd4,
    T_END    = 3'd5
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      tx_data_r;
  logic            tx_eoi_r;
  logic            listening_s;
  logic            talking_s;
  logic            t_abort_s;

  assign listening_s = !bus_atn_i || listen;
  assign talking_s   = talk && bus_atn_i && !listen;
  // Both NRFD and NDAC high on the first settle tick means no listener is on the bus.
  assign t_abort_s   = !bus_atn_i || (cnt_r >= TIMEOUT_C) ||
                       ((state_r == T_SETTLE) && (cnt_r == CNT_ZERO) && bus_nrfd_i && bus_ndac_i);

  // Handshake FSM, state counter, byte latches and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      tx_data_r  <= 8'h00;
      tx_eoi_r   <= 1'b0;
      bus_data_o <= 8'hFF;
      bus_dav_o  <= 1'b1;
      bus_eoi_o  <= 1'b1;
      bus_nrfd_o <= 1'b1;
      bus_ndac_o <= 1'b1;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      rx_eoi     <= 1'b0;
      rx_atn     <= 1'b0;
      tx_ready   <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      tx_err   <= 1'b0;
      if (rx_ready && rx_valid) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
      if (ce) begin
        // Lines default to released each tick; each state re-asserts what it owns.
        bus_data_o <= 8'hFF;
        bus_dav_o  <= 1'b1;
        bus_eoi_o  <= 1'b1;
        bus_nrfd_o <= 1'b1;
        bus_ndac_o <= 1'b1;
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
        case (state_r)
          IDLE: begin
            if (listening_s) begin
              state_r    <= L_WAIT;
              cnt_r      <= CNT_ZERO;
              bus_ndac_o <= 1'b0;
              bus_nrfd_o <= ~rx_valid;
            end else if (talking_s && tx_valid) begin
              state_r    <= T_SETTLE;
              cnt_r      <= CNT_ZERO;
              tx_data_r  <= tx_data;
              tx_eoi_r   <= tx_eoi;
              bus_data_o <= ~tx_data;
              bus_eoi_o  <= ~tx_eoi;
            end else begin
              state_r <= IDLE;
            end
          end
          L_WAIT: begin
            if (!listening_s) begin
              state_r <= IDLE;
              cnt_r   <= CNT_ZERO;
            end else if (!bus_dav_i && bus_nrfd_o && !rx_valid) begin
              state_r    <= L_ACK;
              cnt_r      <= CNT_ZERO;
              rx_data    <= ~bus_data_i;
              rx_eoi     <= ~bus_eoi_i;
              rx_atn     <= ~bus_atn_i;
              rx_valid   <= 1'b1;
              bus_nrfd_o <= 1'b0;
            end else begin
              bus_ndac_o <= 1'b0;
              bus_nrfd_o <= ~rx_valid;
            end
          end
          L_ACK: begin
            if (bus_dav_i) begin
              state_r    <= L_WAIT;
              cnt_r      <= CNT_ZERO;
              bus_ndac_o <= 1'b0;
              bus_nrfd_o <= ~rx_valid;
            end else begin
              bus_nrfd_o <= 1'b0;
            end
          end
          T_SETTLE: begin
            if (t_abort_s) begin
              state_r <= IDLE;
              cnt_r   <= CNT_ZERO;
              tx_err  <= 1'b1;
            end else if ((cnt_r >= SETTLE_C) && bus_nrfd_i) begin
              state_r    <= T_DAV;
              cnt_r      <= CNT_ZERO;
              bus_data_o <= ~tx_data_r;
              bus_eoi_o  <= ~tx_eoi_r;
              bus_dav_o  <= 1'b0;
            end else begin
              bus_data_o <= ~tx_data_r;
              bus_eoi_o  <= ~tx_eoi_r;
            end
          end
          T_DAV: begin
            if (t_abort_s) begin
              state_r <= IDLE;
              cnt_r   <= CNT_ZERO;
              tx_err  <= 1'b1;
            end else if (bus_ndac_i) begin
              state_r  <= T_END;
              cnt_r    <= CNT_ZERO;
              tx_ready <= 1'b1;
            end else begin
              bus_data_o <= ~tx_data_r;
              bus_eoi_o  <= ~tx_eoi_r;
              bus_dav_o  <= 1'b0;
            end
          end
          T_END: begin
            // The byte is already acknowledged here, so ATN is not treated as an abort.
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_ieee488_drive_hs.sv
// Directed bench for ieee488_drive_hs: listener, ATN holdoff, talker, aborts and reset.
module tb_ieee488_drive_hs;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic [7:0] bus_data_i;
  logic       bus_atn_i, bus_dav_i, bus_eoi_i, bus_nrfd_i, bus_ndac_i;
  logic [7:0] bus_data_o;
  logic       bus_dav_o, bus_eoi_o, bus_nrfd_o, bus_ndac_o;
  logic       listen, talk;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_eoi, rx_atn, rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_eoi, tx_ready, tx_err;

  int checks = 0;
  int errors = 0;
  int wait_n;

  ieee488_drive_hs #(.SETTLE(4), .TIMEOUT(4096)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .bus_data_i(bus_data_i), .bus_atn_i(bus_atn_i), .bus_dav_i(bus_dav_i),
    .bus_eoi_i(bus_eoi_i), .bus_nrfd_i(bus_nrfd_i), .bus_ndac_i(bus_ndac_i),
    .bus_data_o(bus_data_o), .bus_dav_o(bus_dav_o), .bus_eoi_o(bus_eoi_o),
    .bus_nrfd_o(bus_nrfd_o), .bus_ndac_o(bus_ndac_o),
    .listen(listen), .talk(talk),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_eoi(rx_eoi), .rx_atn(rx_atn),
    .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_eoi(tx_eoi),
    .tx_ready(tx_ready), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ce = 1'b1; bus_data_i = 8'hFF;
    bus_atn_i = 1'b1; bus_dav_i = 1'b1; bus_eoi_i = 1'b1; bus_nrfd_i = 1'b1; bus_ndac_i = 1'b1;
    listen = 1'b0; talk = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_eoi = 1'b0;
    tick(2);
    check("reset_lines", {20'd0, bus_data_o, bus_dav_o, bus_eoi_o, bus_nrfd_o, bus_ndac_o}, 32'h0000_0FFF);
    check("reset_status", {20'd0, rx_valid, rx_data, rx_eoi, rx_atn, tx_ready, tx_err}, 32'h0);

    // ce low freezes the FSM
    reset_n = 1'b1; ce = 1'b0; listen = 1'b1;
    tick(2);
    check("ce_gate_ndac", {31'd0, bus_ndac_o}, 32'd1);
    ce = 1'b1;
    tick(1);
    check("lwait_nrfd_ndac", {30'd0, bus_nrfd_o, bus_ndac_o}, 32'b10);

    // Listener byte: DIO level BD -> 42
    bus_data_i = 8'hBD; bus_dav_i = 1'b0;
    tick(1);
    check("lbyte_rx", {21'd0, rx_valid, rx_data, rx_eoi, rx_atn}, {21'd0, 1'b1, 8'h42, 1'b0, 1'b0});
    check("lbyte_ndac_rel", {30'd0, bus_ndac_o, bus_nrfd_o}, 32'b10);
    tick(1);
    check("lbyte_ndac_hold", {31'd0, bus_ndac_o}, 32'd1);
    bus_dav_i = 1'b1; bus_data_i = 8'hFF;
    tick(1);
    check("lbyte_back_wait", {30'd0, bus_ndac_o, bus_nrfd_o}, 32'b00);
    rx_ready = 1'b1;
    tick(1);
    check("lbyte_consumed", {31'd0, rx_valid}, 32'd0);
    rx_ready = 1'b0;
    tick(1);
    check("lbyte_nrfd_rel", {31'd0, bus_nrfd_o}, 32'd1);

    // ATN holdoff: leave 8'h01 unread, then offer command 8'h3F under ATN
    bus_data_i = 8'hFE; bus_dav_i = 1'b0;
    tick(1);
    check("hold_first", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h01});
    bus_dav_i = 1'b1; bus_data_i = 8'hFF;
    tick(1);
    listen = 1'b0; bus_atn_i = 1'b0; bus_data_i = 8'hC0; bus_dav_i = 1'b0;
    tick(3);
    check("hold_stall", {21'd0, bus_nrfd_o, bus_ndac_o, rx_valid, rx_data}, {21'd0, 1'b0, 1'b0, 1'b1, 8'h01});
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    check("hold_cmd_rx", {21'd0, rx_valid, rx_data, rx_eoi, rx_atn}, {21'd0, 1'b1, 8'h3F, 1'b0, 1'b1});
    bus_dav_i = 1'b1; bus_data_i = 8'hFF;
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0; bus_atn_i = 1'b1;
    tick(1);
    check("unlisten_release", {30'd0, bus_nrfd_o, bus_ndac_o}, 32'b11);

    // Talker with EOI: 0D -> DIO F2, EOI low, DAV after SETTLE+1 ticks
    talk = 1'b1; tx_valid = 1'b1; tx_data = 8'h0D; tx_eoi = 1'b1; bus_nrfd_i = 1'b1; bus_ndac_i = 1'b0;
    tick(1);
    check("talk_drive", {22'd0, bus_data_o, bus_eoi_o, bus_dav_o}, {22'd0, 8'hF2, 1'b0, 1'b1});
    tick(4);
    check("talk_settle_dav_hi", {30'd0, bus_dav_o, tx_ready}, 32'b10);
    tick(1);
    check("talk_dav_lo", {22'd0, bus_data_o, bus_eoi_o, bus_dav_o}, {22'd0, 8'hF2, 1'b0, 1'b0});
    bus_ndac_i = 1'b1;
    tick(1);
    check("talk_ack", {21'd0, tx_ready, tx_err, bus_dav_o, bus_data_o}, {21'd0, 1'b1, 1'b0, 1'b1, 8'hFF});
    tx_valid = 1'b0;
    tick(1);
    check("talk_ready_single", {31'd0, tx_ready}, 32'd0);
    bus_ndac_i = 1'b0;
    tick(1);

    // Device not present: NRFD and NDAC both released at byte start
    tx_valid = 1'b1; tx_data = 8'h55; tx_eoi = 1'b0; bus_nrfd_i = 1'b1; bus_ndac_i = 1'b1;
    tick(1);
    check("dnp_drive", {24'd0, bus_data_o}, 32'h0000_00AA);
    tick(1);
    check("dnp_abort", {20'd0, tx_err, tx_ready, bus_data_o, bus_dav_o, bus_eoi_o}, {20'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1});
    tx_valid = 1'b0;
    tick(1);
    check("dnp_err_single", {30'd0, tx_err, tx_ready}, 32'd0);

    // Timeout: listener holds NRFD low forever
    bus_ndac_i = 1'b0; bus_nrfd_i = 1'b0; tx_valid = 1'b1; tx_data = 8'h33;
    tick(1);
    wait_n = 0;
    for (int i = 1; i <= 5000; i++) begin
      tick(1);
      if (tx_err) begin
        wait_n = i;
        break;
      end
    end
    check("timeout_window", {31'd0, (wait_n >= 4096) && (wait_n <= 4098)}, 32'd1);
    check("timeout_release", {23'd0, bus_dav_o, bus_data_o}, {23'd0, 1'b1, 8'hFF});
    tx_valid = 1'b0; bus_nrfd_i = 1'b1;
    tick(1);

    // ATN falls while DAV is asserted
    tx_valid = 1'b1; tx_data = 8'h81;
    tick(6);
    check("atn_pre_dav", {23'd0, bus_dav_o, bus_data_o}, {23'd0, 1'b0, 8'h7E});
    bus_atn_i = 1'b0;
    tick(1);
    check("atn_abort", {22'd0, tx_err, bus_dav_o, bus_data_o}, {22'd0, 1'b1, 1'b1, 8'hFF});
    tx_valid = 1'b0;
    tick(1);
    check("atn_ndac_ack", {31'd0, bus_ndac_o}, 32'd0);
    bus_atn_i = 1'b1;
    tick(1);

    // Reset in T_DAV with an unread byte pending
    listen = 1'b1;
    tick(1);
    bus_data_i = 8'h00; bus_dav_i = 1'b0;
    tick(1);
    bus_dav_i = 1'b1; bus_data_i = 8'hFF;
    tick(1);
    listen = 1'b0;
    tick(1);
    tx_valid = 1'b1; tx_data = 8'h12; bus_nrfd_i = 1'b1; bus_ndac_i = 1'b0;
    tick(6);
    check("rst_pre", {30'd0, bus_dav_o, rx_valid}, 32'b01);
    reset_n = 1'b0;
    tick(1);
    check("rst_lines", {20'd0, bus_data_o, bus_dav_o, bus_eoi_o, bus_nrfd_o, bus_ndac_o}, 32'h0000_0FFF);
    check("rst_status", {29'd0, rx_valid, tx_ready, tx_err}, 32'd0);
    reset_n = 1'b1; tx_valid = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
